// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax datapath.
// Used by softmax_max_sub and vec_buf.
package softmax_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } max_sub_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] most_neg(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/vec_buf.sv
// Vector buffer: N x BITS registers,
// one synchronous write port, one combinational read port.
module vec_buf
  import softmax_pkg::*;
#(
  parameter int BITS = 32,
  parameter int N    = 16,
  parameter int IW   = idx_bits(N)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   wa,
  input  logic [BITS-1:0] wd,
  input  logic [IW-1:0]   ra,
  output logic [BITS-1:0] rd
);

  logic [BITS-1:0] mem [N];

  // element storage, written on accept
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers one N-element vector, tracks its max, re-streams element - max.
// Define SOFTMAX_MAX_SUB_SAT_EN to saturate negative overflow instead of wrapping.
module softmax_max_sub
  import softmax_pkg::*;
#(
  parameter int BITS      = 32,
  parameter     PRECISION = "FIXED_16_16",
  parameter int N         = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] c,
  output logic            out_last
);

  localparam int IW = idx_bits(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("softmax_max_sub: N must be at least 2");
  end
  if (PRECISION[$bits(PRECISION)-1 -: 48] != "FIXED_") begin : g_bad_prec
    $error("softmax_max_sub: only FIXED_* formats are supported");
  end

  max_sub_state_t  state;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic [BITS-1:0] max_r;
  logic [BITS-1:0] rd_data;
  logic [BITS-1:0] diff;
  logic [BITS-1:0] sub_res;
  logic            accept;

  assign accept = in_valid && in_ready;

  vec_buf #(
    .BITS (BITS),
    .N    (N),
    .IW   (IW)
  ) u_buf (
    .clk (clk),
    .we  (accept),
    .wa  (wr_idx),
    .wd  (a),
    .ra  (rd_idx),
    .rd  (rd_data)
  );

`ifdef SOFTMAX_MAX_SUB_SAT_EN
  localparam logic [BITS-1:0] MIN_NEG = BITS'(most_neg(BITS));
  logic ovf;

  // subtract; clamp when operand signs differ and result sign flips
  always_comb begin
    diff    = rd_data - max_r;
    ovf     = (rd_data[BITS-1] != max_r[BITS-1]) &&
              (diff[BITS-1] != rd_data[BITS-1]);
    sub_res = ovf ? MIN_NEG : diff;
  end
`else
  // subtract modulo 2^BITS
  always_comb begin
    diff    = rd_data - max_r;
    sub_res = diff;
  end
`endif

  // load/drain sequencing, max tracking and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      c         <= '0;
      max_r     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (accept) begin
            if (wr_idx == '0)
              max_r <= a;
            else if ($signed(a) > $signed(max_r))
              max_r <= a;
            if (wr_idx == LAST) begin
              wr_idx   <= '0;
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          c         <= sub_res;
          out_valid <= 1'b1;
          out_last  <= (rd_idx == LAST);
          if (rd_idx == LAST) begin
            rd_idx   <= '0;
            state    <= LOAD;
            in_ready <= 1'b1;
          end else begin
            rd_idx <= rd_idx + IW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Randomized + directed bench for softmax_max_sub (N = 4, Q16.16).
// Expectations come from a vector-level model of the timing rules.
module tb_softmax_max_sub;

  localparam int BITS = 32;
  localparam int N    = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid;
  logic [BITS-1:0] a;
  logic            in_ready;
  logic            out_valid;
  logic [BITS-1:0] c;
  logic            out_last;

  softmax_max_sub #(
    .BITS      (BITS),
    .PRECISION ("FIXED_16_16"),
    .N         (N)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .a         (a),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .c         (c),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int              k;
  int              last_e;
  logic            exp_rdy;
  logic            exp_vld;
  logic            exp_lst;
  logic [BITS-1:0] exp_c;
  logic [BITS-1:0] acc_q[$];
  logic [BITS-1:0] expv [N];
  logic            last_acc;
  int              n_out;

  task automatic chk(input string tag, input logic [BITS-1:0] got,
                     input logic [BITS-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BITS-1:0] ref_sub(input logic [BITS-1:0] e,
                                               input logic [BITS-1:0] m);
    longint d;
    d = longint'($signed(e)) - longint'($signed(m));
`ifdef SOFTMAX_MAX_SUB_SAT_EN
    if (d < -longint'(64'h8000_0000)) return 32'h8000_0000;
`endif
    return d[BITS-1:0];
  endfunction

  task automatic finish_vec();
    logic [BITS-1:0] mx;
    mx = acc_q[0];
    foreach (acc_q[i])
      if ($signed(acc_q[i]) > $signed(mx)) mx = acc_q[i];
    foreach (acc_q[i]) expv[i] = ref_sub(acc_q[i], mx);
    acc_q.delete();
  endtask

  task automatic model_reset();
    k       = 0;
    last_e  = -100;
    exp_rdy = 1'b1;
    acc_q.delete();
  endtask

  // one clock: drive, update model at the edge, check at the falling edge
  task automatic step(input logic v, input logic [BITS-1:0] d);
    int dt;
    in_valid = v;
    a        = d;
    @(posedge clk);
    last_acc = v && exp_rdy;
    k++;
    if (last_acc) begin
      acc_q.push_back(d);
      if (acc_q.size() == N) begin
        finish_vec();
        last_e = k;
      end
    end
    dt      = k - last_e;
    exp_rdy = !(dt >= 0 && dt <= N - 1);
    exp_vld = (dt >= 1 && dt <= N);
    exp_lst = (dt == N);
    exp_c   = exp_vld ? expv[dt-1] : '0;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("out_last", 32'(out_last), 32'(exp_lst));
    if (exp_vld) begin
      chk("c", c, exp_c);
      n_out++;
    end
  endtask

  task automatic send_vec(input logic [BITS-1:0] v[N], input int gap);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    while (idx < N && guard < 100) begin
      step(1'b1, v[idx]);
      guard++;
      if (last_acc) begin
        idx++;
        repeat (gap) step(1'b0, 32'hDEAD_BEEF);
      end
    end
    if (idx < N) begin
      errors++;
      $error("FAIL send_vec timeout got %0d expected %0d", idx, N);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  logic [BITS-1:0] v[N];
  int              out_before;

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    n_out    = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst c", c, 32'd0);

    v = '{32'h0001_0000, 32'h0003_0000, 32'hFFFE_0000, 32'h0003_0000};
    send_vec(v, 0);
    idle(N + 2);

    v = '{32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFE_0000, 32'hFFF8_0000};
    send_vec(v, 0);
    idle(N + 2);

    v = '{32'h7FFF_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    send_vec(v, 0);
    idle(N + 2);

    out_before = n_out;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) v[i] = $urandom;
      send_vec(v, 0);
    end
    idle(N + 2);
    chk("b2b count", 32'(n_out - out_before), 32'(3 * N));

    v = '{32'h0002_0000, 32'hFFFF_8000, 32'h0002_8000, 32'h0000_0000};
    send_vec(v, 1);
    idle(N + 2);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        v[i] = (r % 2 == 0) ? $urandom
                            : (32'($urandom_range(0, 3)) << 16) - 32'h0002_0000;
      send_vec(v, $urandom_range(0, 2));
    end
    idle(N + 2);

    v = '{32'h0001_0000, 32'h0004_0000, 32'h0002_0000, 32'h0003_0000};
    send_vec(v, 0);
    step(1'b0, '0);
    step(1'b0, '0);
    rstn = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst out_last", 32'(out_last), 32'd0);
    chk("mid rst c", c, 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    v = '{32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000};
    send_vec(v, 0);
    idle(N + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
